// File: rtl/tournament_predictor_pkg.sv
// tournament_pkg: shared types and sizing helpers for the tournament predictor
package tournament_pkg;
  typedef enum logic {SWEEP, RUN} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_INIT, OP_INC, OP_DEC} ctr_op_t;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int ab = a > b ? a : b;
    int cd = c > d ? c : d;
    return ab > cd ? ab : cd;
  endfunction
  function automatic int weak_ctr(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int lctr_idx(input int lp_idx, input int lh_len);
    return lp_idx + lh_len;
  endfunction
endpackage

// File: rtl/tournament_predictor_if.sv
// tournament_predictor_if: fetch/predict and resolve signals of the tournament predictor
interface tournament_predictor_if #(parameter int IP_W = 16, parameter int QDEPTH = 4);
  logic fetch_valid;
  logic [IP_W-1:0] fetch_ip;
  logic pred_taken;
  logic pred_src;
  logic pred_ready;
  logic resolve_valid;
  logic resolve_is_br;
  logic resolve_taken;
  logic flush;
  logic mispredict;
  logic [$clog2(QDEPTH):0] inflight;
  modport master (
    output fetch_valid, fetch_ip, resolve_valid, resolve_is_br, resolve_taken, flush,
    input pred_taken, pred_src, pred_ready, mispredict, inflight
  );
  modport slave (
    input fetch_valid, fetch_ip, resolve_valid, resolve_is_br, resolve_taken, flush,
    output pred_taken, pred_src, pred_ready, mispredict, inflight
  );
endinterface

// File: rtl/tournament_predictor_sat_ctr_table.sv
// sat_ctr_table: saturating counter RAM with async read and one sync init/inc/dec write port
module sat_ctr_table
  import tournament_pkg::*;
#(
  parameter int IDX = 10,
  parameter int W = 2
) (
  input  logic           clk,
  input  ctr_op_t        op,
  input  logic [IDX-1:0] widx,
  input  logic [IDX-1:0] ridx,
  output logic [W-1:0]   rdata
);
  logic [W-1:0] mem [2**IDX];
  logic [W-1:0] cur;
  assign cur = mem[widx];
  assign rdata = mem[ridx];
  always_ff @(posedge clk)
    if (op != OP_NONE)
      mem[widx] <= op == OP_INIT ? W'(weak_ctr(W)) :
                   op == OP_INC  ? (&cur ? cur : cur + W'(1)) :
                                   (|cur ? cur - W'(1) : cur);
endmodule

// File: rtl/tournament_predictor.sv
// tournament_predictor: local/gshare tournament predictor with in-flight metadata queue and clear sweep
module tournament_predictor
  import tournament_pkg::*;
#(
  parameter int IP_W     = 16,
  parameter int LH_IDX   = 10,
  parameter int LH_LEN   = 6,
  parameter int LP_IDX   = 5,
  parameter int G_IDX    = 10,
  parameter int GH_LEN   = 12,
  parameter int M_IDX    = 10,
  parameter int CTR_BITS = 2,
  parameter int QDEPTH   = 4
) (
  input logic clk,
  input logic rst,
  tournament_predictor_if.slave bus
);
  localparam int LC_IDX = lctr_idx(LP_IDX, LH_LEN);
  localparam int MAXI = max4(LH_IDX, LC_IDX, G_IDX, M_IDX);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  typedef struct packed {
    logic [LC_IDX-1:0] lidx;
    logic [G_IDX-1:0]  gidx;
    logic [M_IDX-1:0]  midx;
    logic [LH_IDX-1:0] lhidx;
    logic pl;
    logic pg;
    logic pt;
  } entry_t;
  state_t state, state_n;
  logic [MAXI-1:0] idx;
  logic [LH_LEN-1:0] lhist [2**LH_IDX];
  logic [GH_LEN-1:0] ghr;
  logic [2*G_IDX-1:0] gx;
  entry_t q [QDEPTH];
  entry_t head, ent_f;
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] count;
  logic [IP_W-1:0] ip;
  logic [CTR_BITS-1:0] lc, gc, mc;
  logic sweep, run, ready, push, pop, upd, tk, pm;
  ctr_op_t lop, gop, mop;
  logic unused_ok;
  assign ip = bus.fetch_ip;
  assign sweep = state == SWEEP;
  assign run = state == RUN;
  assign tk = bus.resolve_taken;
  assign ready = run && count != CW'(QDEPTH);
  assign push = bus.fetch_valid && ready && !bus.flush;
  assign pop = run && bus.resolve_valid && count != '0;
  assign head = q[rd];
  assign upd = pop && bus.resolve_is_br;
  // Folded GHR: upper history bits are zero-extended and xored onto the lower ones
  assign gx = (2*G_IDX)'(ghr);
  assign pm = mc[CTR_BITS-1];
  assign ent_f = '{
    lidx:  {ip[LP_IDX-1:0], lhist[ip[LH_IDX-1:0]]},
    gidx:  ip[G_IDX-1:0] ^ gx[G_IDX-1:0] ^ gx[2*G_IDX-1:G_IDX],
    midx:  ip[M_IDX-1:0],
    lhidx: ip[LH_IDX-1:0],
    pl:    lc[CTR_BITS-1],
    pg:    gc[CTR_BITS-1],
    pt:    pm ? gc[CTR_BITS-1] : lc[CTR_BITS-1]
  };
  assign lop = sweep ? OP_INIT : upd ? (tk ? OP_INC : OP_DEC) : OP_NONE;
  assign gop = lop;
  assign mop = sweep ? OP_INIT : (upd && head.pl != head.pg) ? (head.pg == tk ? OP_INC : OP_DEC) : OP_NONE;
  always_comb state_n = (sweep && &idx) ? RUN : state;
  always_ff @(posedge clk)
    if (rst) begin
      state <= SWEEP;
      idx <= '0;
    end else begin
      state <= state_n;
      idx <= sweep ? idx + MAXI'(1) : idx;
    end
  sat_ctr_table #(.IDX(LC_IDX), .W(CTR_BITS)) u_local (
    .clk(clk), .op(lop), .widx(sweep ? idx[LC_IDX-1:0] : head.lidx), .ridx(ent_f.lidx), .rdata(lc)
  );
  sat_ctr_table #(.IDX(G_IDX), .W(CTR_BITS)) u_global (
    .clk(clk), .op(gop), .widx(sweep ? idx[G_IDX-1:0] : head.gidx), .ridx(ent_f.gidx), .rdata(gc)
  );
  sat_ctr_table #(.IDX(M_IDX), .W(CTR_BITS)) u_meta (
    .clk(clk), .op(mop), .widx(sweep ? idx[M_IDX-1:0] : head.midx), .ridx(ent_f.midx), .rdata(mc)
  );
  always_ff @(posedge clk) begin
    if (sweep)
      lhist[idx[LH_IDX-1:0]] <= '0;
    else if (upd)
      lhist[head.lhidx] <= LH_LEN'({lhist[head.lhidx], tk});
    if (push)
      q[wr] <= ent_f;
  end
  // A resolve in the flush cycle still trains the tables before the queue is dropped
  always_ff @(posedge clk)
    if (rst) begin
      ghr <= '0;
      rd <= '0;
      wr <= '0;
      count <= '0;
      bus.mispredict <= 1'b0;
    end else begin
      bus.mispredict <= upd && head.pt != tk;
      ghr <= upd ? GH_LEN'({ghr, tk}) : ghr;
      rd <= bus.flush ? '0 : rd + AW'(pop);
      wr <= bus.flush ? '0 : wr + AW'(push);
      count <= bus.flush ? '0 : count + CW'(push) - CW'(pop);
    end
  assign bus.pred_ready = ready;
  assign bus.pred_taken = run && ent_f.pt;
  assign bus.pred_src = run && pm;
  assign bus.inflight = count;
  assign unused_ok = &{1'b0, ip, lc, gc, mc};
endmodule

// File: tb/tb_tournament_predictor.sv
// tb_tournament_predictor: randomized scoreboard bench against an array-based reference model
module tb_tournament_predictor;
  localparam int QD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tournament_predictor_if #(.IP_W(16), .QDEPTH(QD)) bus();
  tournament_predictor dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {int lidx; int gidx; int midx; int lhidx; bit pl; bit pg; bit pt;} ment_t;
  typedef struct {bit pt; bit ps;} pexp_t;
  typedef struct {bit mis; int infl; bit rdy;} rexp_t;
  int lc [2048];
  int gc [1024];
  int mc [1024];
  int lh [1024];
  int ghr;
  ment_t mq[$];
  pexp_t pq[$];
  rexp_t rq[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask
  function automatic int sat(input int v);
    return v < 0 ? 0 : v > 3 ? 3 : v;
  endfunction
  task automatic model_init();
    foreach (lc[i]) lc[i] = 1;
    foreach (gc[i]) gc[i] = 1;
    foreach (mc[i]) mc[i] = 1;
    foreach (lh[i]) lh[i] = 0;
    ghr = 0;
    mq.delete();
    pq.delete();
    rq.delete();
  endtask
  task automatic idle_inputs();
    bus.fetch_valid = 1'b0;
    bus.fetch_ip = '0;
    bus.resolve_valid = 1'b0;
    bus.resolve_is_br = 1'b0;
    bus.resolve_taken = 1'b0;
    bus.flush = 1'b0;
  endtask
  task automatic step(input bit fv, input int ip, input bit rv, input bit br, input bit tk, input bit fl);
    ment_t e, h;
    pexp_t p;
    rexp_t r;
    bit rdy, mis;
    @(negedge clk);
    bus.fetch_valid = fv;
    bus.fetch_ip = 16'(ip);
    bus.resolve_valid = rv;
    bus.resolve_is_br = br;
    bus.resolve_taken = tk;
    bus.flush = fl;
    e.lhidx = ip % 1024;
    e.lidx = (ip % 32) * 64 + lh[e.lhidx];
    e.gidx = (ip % 1024) ^ (ghr % 1024) ^ (ghr / 1024);
    e.midx = ip % 1024;
    e.pl = lc[e.lidx] >= 2;
    e.pg = gc[e.gidx] >= 2;
    e.pt = mc[e.midx] >= 2 ? e.pg : e.pl;
    rdy = mq.size() < QD;
    if (fv && rdy) begin
      p.pt = e.pt;
      p.ps = mc[e.midx] >= 2;
      pq.push_back(p);
    end
    mis = 1'b0;
    if (rv && mq.size() > 0) begin
      h = mq.pop_front();
      if (br) begin
        lc[h.lidx] = sat(lc[h.lidx] + (tk ? 1 : -1));
        gc[h.gidx] = sat(gc[h.gidx] + (tk ? 1 : -1));
        if (h.pl != h.pg) mc[h.midx] = sat(mc[h.midx] + (h.pg == tk ? 1 : -1));
        lh[h.lhidx] = (lh[h.lhidx] * 2 + int'(tk)) % 64;
        ghr = (ghr * 2 + int'(tk)) % 4096;
        mis = h.pt != tk;
      end
    end
    if (fv && rdy && !fl) mq.push_back(e);
    if (fl) mq.delete();
    r.mis = mis;
    r.infl = mq.size();
    r.rdy = mq.size() < QD;
    rq.push_back(r);
  endtask
  initial forever begin
    pexp_t p;
    rexp_t r;
    @(negedge clk);
    #3;
    if (mon_en) begin
      if (bus.fetch_valid && bus.pred_ready) begin
        if (pq.size() == 0) chk("pred_accept", int'(bus.pred_ready), 0);
        else begin
          p = pq.pop_front();
          chk("pred_taken", int'(bus.pred_taken), int'(p.pt));
          chk("pred_src", int'(bus.pred_src), int'(p.ps));
        end
      end
      if (rq.size() > 1) begin
        r = rq.pop_front();
        chk("mispredict", int'(bus.mispredict), int'(r.mis));
        chk("inflight", int'(bus.inflight), r.infl);
        chk("pred_ready", int'(bus.pred_ready), int'(r.rdy));
      end
    end
  end
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask
  task automatic sweep_count(output int n);
    n = 0;
    while (!bus.pred_ready && n < 5000) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
  initial begin
    int n;
    idle_inputs();
    do_reset();
    chk("reset_pred_ready", int'(bus.pred_ready), 0);
    chk("reset_mispredict", int'(bus.mispredict), 0);
    chk("reset_inflight", int'(bus.inflight), 0);
    chk("sweep_pred_taken", int'(bus.pred_taken), 0);
    sweep_count(n);
    chk("sweep_len", n, 2048);
    do_reset();
    repeat (499) @(negedge clk);
    do_reset();
    sweep_count(n);
    chk("sweep_len_restart", n, 2048);
    model_init();
    mon_en = 1'b1;
    step(1, 'h40, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int it = 0; it < 20; it++)
      for (int j = 0; j < 6; j++) begin
        step(1, 'h100, 0, 0, 0, 0);
        step(0, 0, 1, 1, j < 5, 0);
      end
    for (int i = 0; i < 4; i++) step(1, int'($urandom_range(0, 65535)), 0, 0, 0, 0);
    step(1, 'h300, 1, 1, 1'($urandom), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1'($urandom), 0);
    step(1, 'h200, 0, 0, 0, 0);
    step(1, 'h200, 1, 1, 1, 0);
    step(1, 'h200, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 'h500 + 4 * i, 0, 0, 0, 0);
    step(1, 'h510, 1, 1, 1, 1);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 9) < 6,
           $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 31)) * 4,
           1'($urandom), $urandom_range(0, 4) != 0, 1'($urandom), $urandom_range(0, 49) == 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #4;
    chk("pred_queue_drained", pq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
